// File: rtl/gomoku_round_ctrl.sv
// ============================================================================
// Module   : gomoku_round_ctrl
// Purpose  : Round sequencer for the 6x6 gomoku game FSM. Gates buttons, detects
//            placements, scans for five-in-a-row / draw and handles restart.
//            Optional win-cell mask output: GOMOKU_WIN_HIGHLIGHT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gomoku_round_ctrl #(
    parameter int N = 6,
    parameter int L = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic [1:0] board [N*N],
    input  logic [1:0] player,
    output logic       up_o,
    output logic       down_o,
    output logic       left_o,
    output logic       right_o,
    output logic       center_o,
    output logic       fsm_rst_o,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
`ifdef GOMOKU_WIN_HIGHLIGHT_EN
    ,
    output logic [N*N-1:0] win_cells
`endif
);

    localparam int M    = N - L + 1;
    localparam int NWIN = 2*N*M + 2*M*M;
    localparam int IW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    // Window numbering: horizontal, vertical, down-right, down-left groups.
    function automatic int win_start(input int k);
        int kk;
        int r;
        int c;
        if (k < N*M) begin
            r = k / M;
            c = k % M;
        end else if (k < 2*N*M) begin
            kk = k - N*M;
            c  = kk / M;
            r  = kk % M;
        end else if (k < 2*N*M + M*M) begin
            kk = k - 2*N*M;
            r  = kk / M;
            c  = kk % M;
        end else begin
            kk = k - 2*N*M - M*M;
            r  = kk / M;
            c  = kk % M + L - 1;
        end
        return r*N + c;
    endfunction

    function automatic int win_step(input int k);
        if (k < N*M)
            return 1;
        else if (k < 2*N*M)
            return N;
        else if (k < 2*N*M + M*M)
            return N + 1;
        else
            return N - 1;
    endfunction

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_SCAN = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t          r_state;
    logic [1:0]      r_player_q;
    logic [1:0]      r_mover;
    logic [IW-1:0]   r_idx;

    logic [NWIN-1:0] w_hit;
    logic [N*N-1:0]  w_empty;
    logic            w_full;
    logic            w_play;
    logic            w_cur_hit;
    logic            w_last;

    genvar k, j, i;
    generate
        for (k = 0; k < NWIN; k++) begin : g_win
            localparam int START = win_start(k);
            localparam int STEP  = win_step(k);
            logic [L-1:0] w_match;
            for (j = 0; j < L; j++) begin : g_cell
                assign w_match[j] = (board[START + j*STEP] == r_mover);
            end
            assign w_hit[k] = &w_match;
        end

        for (i = 0; i < N*N; i++) begin : g_full
            assign w_empty[i] = (board[i] == 2'b00);
        end
    endgenerate

    assign w_full    = ~|w_empty;
    assign w_play    = (r_state == S_PLAY);
    assign w_cur_hit = w_hit[r_idx];
    assign w_last    = (r_idx == IW'(NWIN - 1));

    assign up_o     = btn_up     & w_play;
    assign down_o   = btn_down   & w_play;
    assign left_o   = btn_left   & w_play;
    assign right_o  = btn_right  & w_play;
    assign center_o = btn_center & w_play;

`ifdef GOMOKU_WIN_HIGHLIGHT_EN
    logic [N*N-1:0] w_mask [NWIN];

    function automatic logic [N*N-1:0] win_mask(input int kw);
        logic [N*N-1:0] m;
        m = '0;
        for (int jj = 0; jj < L; jj++)
            m[win_start(kw) + jj*win_step(kw)] = 1'b1;
        return m;
    endfunction

    generate
        for (k = 0; k < NWIN; k++) begin : g_mask
            localparam logic [N*N-1:0] MASK = win_mask(k);
            assign w_mask[k] = MASK;
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_PLAY;
            r_player_q <= 2'b01;
            r_mover    <= 2'b00;
            r_idx      <= '0;
            winner     <= 2'b00;
            draw       <= 1'b0;
            game_over  <= 1'b0;
            busy       <= 1'b0;
            fsm_rst_o  <= 1'b0;
`ifdef GOMOKU_WIN_HIGHLIGHT_EN
            win_cells  <= '0;
`endif
        end else begin
            fsm_rst_o  <= 1'b0;
            r_player_q <= player;
            case (r_state)
                S_PLAY: begin
                    if (player != r_player_q) begin
                        r_mover <= r_player_q;
                        r_state <= S_SCAN;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_cur_hit) begin
                        r_state   <= S_OVER;
                        winner    <= r_mover;
                        game_over <= 1'b1;
                        busy      <= 1'b0;
`ifdef GOMOKU_WIN_HIGHLIGHT_EN
                        win_cells <= w_mask[r_idx];
`endif
                    end else if (w_last) begin
                        busy <= 1'b0;
                        if (w_full) begin
                            r_state   <= S_OVER;
                            draw      <= 1'b1;
                            winner    <= 2'b00;
                            game_over <= 1'b1;
`ifdef GOMOKU_WIN_HIGHLIGHT_EN
                            win_cells <= '0;
`endif
                        end else begin
                            r_state <= S_PLAY;
                        end
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_OVER: begin
                    if (btn_center) begin
                        fsm_rst_o  <= 1'b1;
                        r_state    <= S_PLAY;
                        winner     <= 2'b00;
                        draw       <= 1'b0;
                        game_over  <= 1'b0;
                        // Game FSM restarts with black to move; keep that from looking like a turn change.
                        r_player_q <= 2'b01;
`ifdef GOMOKU_WIN_HIGHLIGHT_EN
                        win_cells  <= '0;
`endif
                    end
                end
                default: r_state <= S_PLAY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/gomoku_round_ctrl.md
Name: gomoku_round_ctrl

Overview:
- Sequencing controller in front of the 6x6 gomoku game FSM.
- Gates the debounced button pulses into the game FSM and detects each stone placement.
- After each placement, runs a multi-cycle five-in-a-row scan over the board and declares win, draw or continue.
- Holds the game in a game-over state until center is pressed, then issues a one-cycle restart to the game FSM.

Parameters:
- N, 6, board side; cell index i = row*N + col.
- L, 5, stones in a row required to win.
- NWIN, 2*N*(N-L+1) + 2*(N-L+1)^2 (32 at defaults), number of scan windows; derived, not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_up, btn_down, btn_left, btn_right, btn_center  in  1 each  single-cycle debounced button pulses.
- board  in  2 x [N*N] unpacked  game FSM board; 00 empty, 01 black, 10 white.
- player  in  2  game FSM current turn player.
- up_o, down_o, left_o, right_o, center_o  out  1 each  gated buttons to the game FSM.
- fsm_rst_o  out  1  synchronous active-high restart pulse to the game FSM.
- busy  out  1  scan in progress.
- game_over  out  1  round finished.
- winner  out  2  01 black, 10 white, 00 none or draw.
- draw  out  1  board full with no winner.

Behaviour:
- Reset (async, rst_n low):
  - state=PLAY, player_q=01, idx=0.
  - winner=00, draw=0, game_over=0, busy=0, fsm_rst_o=0.
  - Registered outputs take effect immediately.
- Gating (combinational): each *_o = btn_* AND (state==PLAY). Presses arriving in SCAN or OVER are dropped, never queued.
- Placement detect:
  - player_q <= player every cycle.
  - A placement is (state==PLAY) and (player != player_q).
  - On a placement: mover <= player_q, state <= SCAN, idx <= 0, busy=1 from the next cycle.
- SCAN (one window per cycle, idx 0..NWIN-1). Window order at the default N, L:
  - idx 0-11: horizontal, row r, start col c in {0,1}; idx = r*2 + c.
  - idx 12-23: vertical, col c, start row r in {0,1}; idx = 12 + c*2 + r.
  - idx 24-27: down-right diagonal, start (r,c) with r,c in {0,1}; idx = 24 + r*2 + c.
  - idx 28-31: down-left diagonal, start (r,c) with r in {0,1}, c in {4,5}; idx = 28 + r*2 + (c-4).
- Window hit: all L cells == mover.
  - Go to OVER; winner <= mover, game_over <= 1, busy <= 0.
  - Remaining windows are skipped.
- No hit at idx == NWIN-1:
  - If no cell is 00: go to OVER, draw <= 1, winner <= 00, game_over <= 1.
  - Else go to PLAY.
  - busy <= 0 in both cases.
- Latency: the decision is registered at the end of scan cycle idx_hit. Worst case is NWIN cycles from SCAN entry to PLAY or OVER.
- Board stability: the board is stable during SCAN because buttons are gated. A player change during SCAN or OVER is ignored apart from the player_q update.
- OVER:
  - All gated outputs stay 0.
  - btn_center causes fsm_rst_o=1 for exactly the next cycle, and state -> PLAY.
  - winner, draw and game_over clear in the same cycle.
  - player_q is forced to 01 so the game FSM reset is not seen as a placement.
- Simultaneous events:
  - A placement and btn_center in the same PLAY cycle: center passes through normally.
  - Other buttons in OVER: no effect.
- Reset mid-scan: aborts to PLAY with all outputs cleared; no partial result is retained.

Optional Feature:
- Macro: GOMOKU_WIN_HIGHLIGHT_EN.
- Defined:
  - Extra output win_cells [N*N-1:0], registered.
  - On a win, bit i = 1 for each of the L cells of the hit window.
  - Cleared on reset, on the restart pulse and on a draw.
- Undefined: port absent; no mask logic.

Test Plan:
- Reset then idle 10 cycles:
  - game_over=0, busy=0, winner=00, fsm_rst_o=0.
  - btn_left pulse -> left_o=1 in the same cycle.
- Black cells 0-4 on board, player toggles 01->10:
  - busy=1 for 1 cycle (idx 0 hits), then game_over=1, winner=01.
  - With the macro: win_cells=0x1F.
- White on anti-diagonal cells 11,16,21,26,31 (window idx 31), player 10->01:
  - busy high for 32 cycles, then winner=10.
  - btn_down during the scan -> down_o stays 0.
- Board full with no five-in-a-row, last placement:
  - After 32 cycles, draw=1, winner=00, game_over=1.
- In OVER, pulse btn_up, then btn_center:
  - up_o=0.
  - fsm_rst_o=1 for one cycle, flags clear, state PLAY.
  - No spurious scan starts.
- rst_n low at scan cycle 10:
  - busy=0, game_over=0 immediately.
  - After release, PLAY passes buttons through.
